// File: rtl/port_grid_sequencer.sv
// Valve sequencer for a 4x8 port grid: queued {row, col, dur} commands open one
// valve at a time for dur cycles, each followed by a fixed closed settle window.
module port_grid_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DUR_W  = 16,
  parameter int SETTLE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_row,
  input  logic [2:0]       cmd_col,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             abort,
  output logic [31:0]      valve_en,
  output logic             busy,
  output logic             done_pulse,
  output logic             err_pulse
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SET_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_SETTLE} state_t;

  typedef struct packed {
    logic [1:0]       row;
    logic [2:0]       col;
    logic [DUR_W-1:0] dur;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  state_t           state;
  logic [DUR_W-1:0] dur_cnt;
  logic [SET_W-1:0] settle_cnt;

  logic   fifo_full, fifo_empty, handshake, push, reject, pop;
  entry_t head;

  assign fifo_full  = (count == (PTR_W+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign cmd_ready  = !fifo_full && !abort && !rst;
  assign handshake  = cmd_valid && cmd_ready;
  assign push       = handshake && (cmd_dur != '0);
  assign reject     = handshake && (cmd_dur == '0);
  assign head       = mem[rd_ptr];
  assign busy       = (state != S_IDLE) || !fifo_empty;

  // The head is consumed only when the FSM can start a new open interval.
  assign pop = !fifo_empty &&
               ((state == S_IDLE) || (state == S_SETTLE && settle_cnt == SET_W'(1)));

  // NOTE: FIFO storage has no reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{row: cmd_row, col: cmd_col, dur: cmd_dur};
  end

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dur_cnt    <= '0;
      settle_cnt <= '0;
      valve_en   <= '0;
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      err_pulse  <= reject;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        S_IDLE: begin
          if (pop) begin
            valve_en <= 32'd1 << {head.row, head.col};
            dur_cnt  <= head.dur;
            state    <= S_OPEN;
          end
        end
        S_OPEN: begin
          if (dur_cnt == DUR_W'(1)) begin
            valve_en   <= '0;
            done_pulse <= 1'b1;
            dur_cnt    <= '0;
            settle_cnt <= SET_W'(SETTLE);
            state      <= S_SETTLE;
          end else begin
            dur_cnt <= dur_cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SET_W'(1)) begin
            settle_cnt <= '0;
            if (pop) begin
              valve_en <= 32'd1 << {head.row, head.col};
              dur_cnt  <= head.dur;
              state    <= S_OPEN;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_grid_sequencer.sv
// Directed bench for port_grid_sequencer: table of single commands plus
// hand-written back-to-back, FIFO-full, zero-duration, abort and reset sequences.
module tb_port_grid_sequencer;

  localparam int DUR_W = 8;

  logic             clk = 1'b0;
  logic             rst, cmd_valid, abort;
  logic             cmd_ready, busy, done_pulse, err_pulse;
  logic [1:0]       cmd_row;
  logic [2:0]       cmd_col;
  logic [DUR_W-1:0] cmd_dur;
  logic [31:0]      valve_en;

  int n_cmp = 0;
  int n_err = 0;

  port_grid_sequencer #(.DEPTH(4), .DUR_W(DUR_W), .SETTLE(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_dur(cmd_dur), .abort(abort),
    .valve_en(valve_en), .busy(busy), .done_pulse(done_pulse), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       row;
    logic [2:0]       col;
    logic [DUR_W-1:0] dur;
    logic [31:0]      exp_valve;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] r, input logic [2:0] c, input logic [DUR_W-1:0] d);
    cmd_valid = 1'b1;
    cmd_row   = r;
    cmd_col   = c;
    cmd_dur   = d;
  endtask

  task automatic settle_out(input string name);
    for (int i = 0; i < 7; i++) step();
    check({name, " busy in settle"}, busy, 1);
    step();
    check({name, " busy after settle"}, busy, 0);
  endtask

  task automatic run_single(input vec_t v);
    offer(v.row, v.col, v.dur);
    step();
    cmd_valid = 1'b0;
    check("single valve after handshake", valve_en, 0);
    for (int i = 0; i < int'(v.dur); i++) begin
      step();
      check("single valve open", valve_en, v.exp_valve);
    end
    step();
    check("single valve closed", valve_en, 0);
    check("single done", done_pulse, 1);
    settle_out("single");
  endtask

  logic [31:0] seen [$];
  logic [31:0] prev_valve;
  logic        prev_ready, quiet, found;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_row = '0; cmd_col = '0; cmd_dur = '0;
    vecs[0] = '{2'd2, 3'd3, 8'd5,   32'h0008_0000};
    vecs[1] = '{2'd0, 3'd0, 8'd1,   32'h0000_0001};
    vecs[2] = '{2'd3, 3'd7, 8'd3,   32'h8000_0000};
    vecs[3] = '{2'd1, 3'd4, 8'd2,   32'h0000_1000};
    vecs[4] = '{2'd0, 3'd7, 8'hFF,  32'h0000_0080};

    // Reset state
    step(); step();
    cmd_valid = 1'b1; cmd_dur = 8'd3;
    #1;
    check("reset cmd_ready", cmd_ready, 0);
    check("reset valve_en", valve_en, 0);
    check("reset busy", busy, 0);
    check("reset done", done_pulse, 0);
    check("reset err", err_pulse, 0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("ready after reset", cmd_ready, 1);

    // Single commands, including maximum duration
    foreach (vecs[k]) run_single(vecs[k]);

    // Back-to-back: (2,5,3) then (3,4,2)
    offer(2'd2, 3'd5, 8'd3); step();
    offer(2'd3, 3'd4, 8'd2); step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      check("b2b first open", valve_en, 32'h0020_0000);
    end
    step();
    check("b2b first done", done_pulse, 1);
    check("b2b gap", valve_en, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      check("b2b gap", valve_en, 0);
      check("b2b gap done", done_pulse, 0);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      check("b2b second open", valve_en, 32'h1000_0000);
    end
    step();
    check("b2b second done", done_pulse, 1);
    check("b2b second closed", valve_en, 0);
    settle_out("b2b");

    // Zero duration rejected
    offer(2'd1, 3'd1, 8'd0); step();
    cmd_valid = 1'b0;
    check("zero err_pulse", err_pulse, 1);
    check("zero valve", valve_en, 0);
    check("zero busy", busy, 0);
    step();
    check("zero err_pulse width", err_pulse, 0);
    check("zero valve later", valve_en, 0);

    // Fill FIFO behind a dur-100 command, then check order and ready recovery
    offer(2'd0, 3'd1, 8'd100); step();
    cmd_valid = 1'b0;
    step();
    check("fill long open", valve_en, 32'h0000_0002);
    for (int i = 0; i < 4; i++) begin
      offer(2'd1, 3'(i), 8'd1);
      #1;
      check("fill ready before push", cmd_ready, 1);
      step();
    end
    offer(2'd2, 3'd0, 8'd1);
    #1;
    check("fill ready when full", cmd_ready, 0);
    cmd_valid = 1'b0;
    prev_valve = valve_en;
    prev_ready = cmd_ready;
    found = 1'b0;
    seen.delete();
    for (int i = 0; i < 200 && seen.size() < 4; i++) begin
      step();
      check("onehot", 32'($countones(valve_en) <= 1), 1);
      if (valve_en != 0 && valve_en != prev_valve) begin
        seen.push_back(valve_en);
        if (seen.size() == 1) begin
          check("fill ready held low before pop", prev_ready, 0);
          check("fill ready after pop", cmd_ready, 1);
        end
      end
      prev_valve = valve_en;
      prev_ready = cmd_ready;
    end
    check("fill executed count", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      check("fill order", seen[i], 32'h0000_0100 << i);
    for (int i = 0; i < 40 && busy; i++) step();
    check("fill drained", busy, 0);

    // Abort at cycle 10 of a dur-50 command with 3 queued
    offer(2'd2, 3'd2, 8'd50); step();
    offer(2'd0, 3'd0, 8'd5); step();
    check("abort open", valve_en, 32'h0004_0000);
    offer(2'd0, 3'd1, 8'd5); step();
    offer(2'd0, 3'd2, 8'd5); step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("abort still open at cycle 10", valve_en, 32'h0004_0000);
    abort = 1'b1;
    #1;
    check("abort blocks ready", cmd_ready, 0);
    step();
    abort = 1'b0;
    check("abort valve", valve_en, 0);
    check("abort busy", busy, 0);
    check("abort done", done_pulse, 0);
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valve_en != 0 || done_pulse || busy) quiet = 1'b0;
    end
    check("abort stays quiet", quiet, 1);

    // Sync reset mid-SETTLE with 2 queued
    offer(2'd3, 3'd0, 8'd2); step();
    offer(2'd3, 3'd1, 8'd4); step();
    offer(2'd3, 3'd2, 8'd4); step();
    cmd_valid = 1'b0;
    step();
    check("rst test done", done_pulse, 1);
    step(); step();
    check("rst test in settle", busy, 1);
    rst = 1'b1;
    #1;
    check("rst ready low", cmd_ready, 0);
    step();
    rst = 1'b0;
    check("rst valve", valve_en, 0);
    check("rst busy", busy, 0);
    check("rst done", done_pulse, 0);
    check("rst err", err_pulse, 0);
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (valve_en != 0 || done_pulse || busy) quiet = 1'b0;
    end
    check("rst no residual activity", quiet, 1);
    offer(2'd1, 3'd7, 8'd2); step();
    cmd_valid = 1'b0;
    step();
    check("rst new command runs", valve_en, 32'h0000_8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
